// File: rtl/keypad_matrix_emulator_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix-keypad emulator.
//   keypad_state_e : contact sequencing states (IDLE, MAKE, HOLD, BREAK)
//   ROW_IDLE       : active-low row bus value with no contact closed
//   LFSR_SEED/TAPS : bounce-jitter LFSR constants (x^8+x^6+x^5+x^4)
//   key_row/key_col: split a 4-bit key index into matrix coordinates
//   clog2_min1     : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        HOLD  = 2'd2,
        BREAK = 2'd3
    } keypad_state_e;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

    // A counter that only ever needs to hold 0 still needs one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_matrix_emulator_if
// Bundles the keypad matrix lines and the press-command handshake.
//   col[3:0]       : column strobes from the scanner, active-low
//   row[3:0]       : row returns to the scanner, active-low
//   press_req      : single-cycle press command
//   press_key[3:0] : key index sampled with press_req
//   busy / done    : press in progress / release-complete pulse
// Modports: master = scanner/stimulus side, slave = emulator side.
// ---------------------------------------------------------------------------
interface keypad_matrix_emulator_if;

    logic [3:0] col;
    logic [3:0] row;
    logic       press_req;
    logic [3:0] press_key;
    logic       busy;
    logic       done;

    modport master (
        output col,
        output press_req,
        output press_key,
        input  row,
        input  busy,
        input  done
    );

    modport slave (
        input  col,
        input  press_req,
        input  press_key,
        output row,
        output busy,
        output done
    );

endinterface

// File: rtl/keypad_matrix_emulator_bounce_timer.sv
// ---------------------------------------------------------------------------
// keypad_bounce_timer
// Times one contact-bounce phase: BOUNCE_TOGGLES inversions spaced
// BOUNCE_PERIOD cycles apart. With zero toggles the phase lasts one cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : restart the phase counters (phase start edge)
//   run       : a bounce phase is in progress
//   toggle    : contact should invert at the next edge
//   phase_end : the phase finishes at the next edge
// Optional: KEYPAD_EMU_LFSR_BOUNCE_EN adds an 8-bit Fibonacci LFSR that
// stretches each interval by lfsr[1:0] cycles.
// ---------------------------------------------------------------------------
module keypad_bounce_timer
    import keypad_pkg::*;
#(
    parameter int BOUNCE_PERIOD  = 4,
    parameter int BOUNCE_TOGGLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic toggle,
    output logic phase_end
);

    localparam int TW = clog2_min1(BOUNCE_TOGGLES);
    localparam logic [TW-1:0] TOGGLE_LAST =
        TW'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);

`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
    localparam int IW = clog2_min1(BOUNCE_PERIOD + 4);
`else
    localparam int IW = clog2_min1(BOUNCE_PERIOD);
`endif

    logic [IW-1:0] interval_cnt_q;
    logic [TW-1:0] toggle_cnt_q;
    logic [IW-1:0] interval_last;

`ifdef KEYPAD_EMU_LFSR_BOUNCE_EN
    logic [7:0]    lfsr_q;
    logic [IW-1:0] interval_q;

    // Free-running jitter source; it steps every cycle regardless of phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // Each interval length is picked when its predecessor ends (or the phase starts).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_q <= IW'(BOUNCE_PERIOD);
        end else if (load || toggle) begin
            interval_q <= IW'(BOUNCE_PERIOD) + IW'(lfsr_q[1:0]);
        end
    end

    assign interval_last = interval_q - IW'(1);
`else
    assign interval_last = IW'(BOUNCE_PERIOD - 1);
`endif

    // Strobes are decoded from the registered counts so the FSM acts on them at the next edge.
    always_comb begin
        toggle    = 1'b0;
        phase_end = 1'b0;
        if (run) begin
            if (BOUNCE_TOGGLES == 0) begin
                phase_end = 1'b1;
            end else if (interval_cnt_q == interval_last) begin
                toggle    = 1'b1;
                phase_end = (toggle_cnt_q == TOGGLE_LAST);
            end
        end
    end

    // Counters only restart through load or an interval reload, never by wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_cnt_q <= '0;
            toggle_cnt_q   <= '0;
        end else if (load) begin
            interval_cnt_q <= '0;
            toggle_cnt_q   <= '0;
        end else if (toggle) begin
            interval_cnt_q <= '0;
            if (!phase_end) begin
                toggle_cnt_q <= toggle_cnt_q + TW'(1);
            end
        end else if (run) begin
            interval_cnt_q <= interval_cnt_q + IW'(1);
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// ---------------------------------------------------------------------------
// keypad_matrix_emulator
// Responder side of a 4x4 matrix keypad. A press command closes one contact
// with make bounce, holds it, then opens it with break bounce. The row lines
// are decoded combinationally from the column strobes, like a real keypad.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : keypad_matrix_emulator_if.slave (col, row, press_req,
//              press_key, busy, done)
// Parameters: BOUNCE_PERIOD, BOUNCE_TOGGLES (even), HOLD_CYCLES.
// Optional: KEYPAD_EMU_LFSR_BOUNCE_EN jitters bounce intervals (in timer).
// ---------------------------------------------------------------------------
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_PERIOD  = 4,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int HOLD_CYCLES    = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    keypad_matrix_emulator_if.slave      bus
);

    localparam int HW = clog2_min1(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    keypad_state_e state_q, state_d;
    logic          contact_q, contact_d;
    logic [3:0]    key_q, key_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          done_q, done_d;
    logic          timer_load;
    logic          timer_run;
    logic          timer_toggle;
    logic          timer_phase_end;
    logic [3:0]    row_d;

    assign timer_run = (state_q == MAKE) || (state_q == BREAK);

    keypad_bounce_timer #(
        .BOUNCE_PERIOD  (BOUNCE_PERIOD),
        .BOUNCE_TOGGLES (BOUNCE_TOGGLES)
    ) u_bounce_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .run       (timer_run),
        .toggle    (timer_toggle),
        .phase_end (timer_phase_end)
    );

    // State, contact, latched key, hold count and done all register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            contact_q  <= 1'b0;
            key_q      <= 4'd0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            contact_q  <= contact_d;
            key_q      <= key_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
        end
    end

    // Contact closes on acceptance and is forced to its settled value at
    // each bounce phase end, so an odd bounce history can never leak through.
    // Requests arriving outside IDLE are simply not looked at.
    always_comb begin
        state_d    = state_q;
        contact_d  = contact_q;
        key_d      = key_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.press_req) begin
                    key_d      = bus.press_key;
                    state_d    = MAKE;
                    contact_d  = 1'b1;
                    timer_load = 1'b1;
                end
            end
            MAKE: begin
                if (timer_phase_end) begin
                    state_d    = HOLD;
                    contact_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (timer_toggle) begin
                    contact_d  = ~contact_q;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = BREAK;
                    contact_d  = 1'b0;
                    timer_load = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            BREAK: begin
                if (timer_phase_end) begin
                    state_d   = IDLE;
                    contact_d = 1'b0;
                    done_d    = 1'b1;
                end else if (timer_toggle) begin
                    contact_d = ~contact_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row pulls low only while its column is strobed and the contact is closed;
    // other strobed columns have no keys pressed on them.
    always_comb begin
        row_d = ROW_IDLE;
        if (contact_q && !bus.col[key_col(key_q)]) begin
            row_d[key_row(key_q)] = 1'b0;
        end
    end

    assign bus.row  = row_d;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable responder side of the 4x4 matrix-keypad interface: watches the column strobes driven by a keypad scanner and drives the row lines exactly as a physical keypad would.
- Presses are injected by command. The block models contact bounce on make and on break.
- Used for on-board loopback and bench stimulus of scanner blocks in place of hand-written row waveforms.

Parameters:
- BOUNCE_PERIOD, 4: cycles between contact inversions during a bounce phase (>=1).
- BOUNCE_TOGGLES, 4: inversions per bounce phase; must be even (0 allowed).
- HOLD_CYCLES, 100: cycles the contact is held stably closed (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- col, input, 4: column strobes from the scanner, active-low.
- row, output, 4: row returns to the scanner, active-low, idle 4'b1111.
- press_req, input, 1: single-cycle request to press a key.
- press_key, input, 4: key index; row = press_key[3:2], column = press_key[1:0]. Sampled with press_req.
- busy, output, 1: high from acceptance until done.
- done, output, 1: one-cycle pulse when the release bounce completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - State goes to IDLE.
  - contact=0, busy=0, done=0, row=4'b1111.
  - Latched key cleared to 0.
- State machine: IDLE -> MAKE -> HOLD -> BREAK -> IDLE.
- IDLE:
  - press_req=1 latches press_key.
  - At that same edge: state=MAKE, contact=1, busy=1.
- press_req while busy=1 is ignored; it is neither queued nor allowed to alter the latched key.
- MAKE:
  - contact inverts every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times.
  - Phase length is max(1, BOUNCE_PERIOD*BOUNCE_TOGGLES) cycles.
  - At phase end: contact forced to 1, state=HOLD.
- HOLD: contact=1 for HOLD_CYCLES cycles, then state=BREAK with contact=0.
- BREAK:
  - Same bounce pattern as MAKE, starting from contact=0.
  - At phase end: contact forced to 0, state=IDLE, busy=0, done=1 for one cycle.
- Timing with defaults: press_req sampled at edge N gives busy=1 from edge N, HOLD entered at N+16, BREAK at N+116, done pulse and busy fall at N+132.
- Row output (combinational from col and registered state):
  - row[r]=0 iff contact=1 and r==key_row and col[key_col]==0; otherwise row[r]=1.
  - No registered delay from col to row, so scanner settle timing is exercised realistically.
- Multiple columns low simultaneously: only the latched key's column matters.
- All columns high: row=4'b1111 regardless of contact.
- Counters are sized with $clog2 of their maximum and wrap only by explicit reload; no free-running wrap.

Optional Feature:
- KEYPAD_EMU_LFSR_BOUNCE_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, steps every cycle) jitters the bounce timing.
  - Each inversion interval becomes BOUNCE_PERIOD + lfsr[1:0] cycles.
  - Phase length becomes variable. Toggle count and final forced contact value are unchanged.
- Undefined: fixed intervals as above. No LFSR logic is present.

Decomposition:
- Package keypad_pkg:
  - State enum (IDLE, MAKE, HOLD, BREAK).
  - Active-low idle constant ROW_IDLE=4'b1111.
  - Key-index field split functions (key_row, key_col).
  - LFSR seed/taps constants.
- Sub-module keypad_bounce_timer:
  - Loads on phase start.
  - Counts interval and toggles.
  - Emits toggle strobe and phase_end.
  - Contains the optional LFSR.
- Top holds the FSM, latched key and row decode.

Test Plan:
- Reset: rst=1 with col=4'b0000 -> row=4'b1111, busy=0, done=0. Asserting rst at HOLD cycle 50 gives row=4'b1111 and busy=0 immediately, with no done pulse.
- Key 0 press, col held 4'b1110, defaults:
  - row=4'b1110 from edge N.
  - row toggles to 4'b1111/4'b1110 every 4 cycles through N+16.
  - Steady 4'b1110 until N+116, bounce again, 4'b1111 from N+132.
  - done pulses at N+132.
- Key 9 (row 2, col 1) during HOLD:
  - col=4'b1101 -> row=4'b1011.
  - col=4'b1110 -> row=4'b1111.
  - col=4'b0000 -> row=4'b1011.
  - col=4'b1111 -> row=4'b1111.
- press_req with key 5 issued at MAKE cycle 3 -> ignored: key stays 0, done timing is unchanged, and there is exactly one done pulse.
- BOUNCE_TOGGLES=0, HOLD_CYCLES=1 -> one make cycle, one hold cycle, one break cycle; done at N+3.
- Back-to-back: press_req in the cycle after done is accepted, and busy rises at that edge.
